// File: rtl/line_fill_compressor_if.sv
// line_fill_compressor_if
//   Bundles the three handshakes of the miss-fill stage:
//     miss_*      : cache miss request into the block (valid/ready)
//     mem_req_*   : line-read request out to memory (valid/ready)
//     mem_beat_*  : read-data beats back from memory (valid only, no backpressure)
//     fill_*      : completed {address, line, CF} record to the cache (valid/ready)
//   modport slave  : the fill stage itself
//   modport master : the environment around it (cache + memory)
interface line_fill_compressor_if #(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 64,
   parameter int LINE_W = 512
);
   logic              miss_valid;
   logic [ADDR_W-1:0] miss_addr;
   logic              miss_ready;

   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_ready;

   logic              mem_beat_valid;
   logic [BEAT_W-1:0] mem_beat_data;

   logic              fill_valid;
   logic [ADDR_W-1:0] fill_addr;
   logic [LINE_W-1:0] fill_data;
   logic [1:0]        fill_cf;
   logic              fill_ready;

   modport slave (
      input  miss_valid, miss_addr, mem_req_ready, mem_beat_valid, mem_beat_data, fill_ready,
      output miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data, fill_cf
   );

   modport master (
      output miss_valid, miss_addr, mem_req_ready, mem_beat_valid, mem_beat_data, fill_ready,
      input  miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data, fill_cf
   );
endinterface

// File: rtl/line_fill_compressor.sv
// line_fill_compressor
//   Miss-fill stage in front of the compressed cache fill path. Accepts one
//   line miss at a time, issues a line-aligned memory read, assembles the
//   returned beats into a line while tracking which upper portions are zero,
//   then hands {address, line, CF} to the cache and counts fills per CF.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   bus (slave)      : miss / mem_req / mem_beat / fill handshakes
//   cnt_cf0..cnt_cf2 : completed fills per CF (none, /2, /4), wrap on overflow
module line_fill_compressor #(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 64,
   parameter int LINE_W = 512,
   parameter int CNT_W  = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   line_fill_compressor_if.slave  bus,
   output logic [CNT_W-1:0]       cnt_cf0,
   output logic [CNT_W-1:0]       cnt_cf1,
   output logic [CNT_W-1:0]       cnt_cf2
);

   localparam int NBEATS = LINE_W / BEAT_W;
   localparam int K_W    = $clog2(NBEATS);
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int HALF   = NBEATS / 2;
   localparam int QTR    = NBEATS / 4;

   typedef enum logic [1:0] {IDLE, REQ, FILL, OUT} state_t;

   state_t            state_q, state_n;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] line_q;
   logic [K_W-1:0]    k_q;
   logic              z2_q, z4_q;
   logic              z2_n, z4_n;
   logic [1:0]        cf_q;
   logic              beat_nz;
   logic              last_beat;

   // /4 wins over /2: a line whose upper three quarters are zero also has a
   // zero upper half, and an all-zero line lands here too.
   function automatic logic [1:0] classify(input logic z2, input logic z4);
      if (z4)      return 2'b10;
      else if (z2) return 2'b01;
      else         return 2'b00;
   endfunction

   // Flags are updated from the beat being written this cycle so that the
   // final CF can be captured on the same edge as the last beat.
   always_comb begin
      beat_nz   = |bus.mem_beat_data;
      z2_n      = z2_q & ~(beat_nz && (k_q >= K_W'(HALF)));
      z4_n      = z4_q & ~(beat_nz && (k_q >= K_W'(QTR)));
      last_beat = (k_q == K_W'(NBEATS - 1));
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (bus.miss_valid)                  state_n = REQ;
         REQ:     if (bus.mem_req_ready)               state_n = FILL;
         FILL:    if (bus.mem_beat_valid && last_beat) state_n = OUT;
         OUT:     if (bus.fill_ready)                  state_n = IDLE;
         default:                                      state_n = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.miss_ready    = (state_q == IDLE);
      bus.mem_req_valid = (state_q == REQ);
      bus.fill_valid    = (state_q == OUT);
      bus.mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      bus.fill_addr     = addr_q;
      bus.fill_data     = line_q;
      bus.fill_cf       = cf_q;
   end

   // Datapath and statistics; beats outside FILL never touch line or flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q  <= '0;
         line_q  <= '0;
         k_q     <= '0;
         z2_q    <= 1'b1;
         z4_q    <= 1'b1;
         cf_q    <= 2'b00;
         cnt_cf0 <= '0;
         cnt_cf1 <= '0;
         cnt_cf2 <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.miss_valid) begin
                  addr_q <= bus.miss_addr;
                  line_q <= '0;
                  k_q    <= '0;
                  z2_q   <= 1'b1;
                  z4_q   <= 1'b1;
               end
            end
            FILL: begin
               if (bus.mem_beat_valid) begin
                  for (int i = 0; i < NBEATS; i++) begin
                     if (k_q == K_W'(i)) line_q[i*BEAT_W +: BEAT_W] <= bus.mem_beat_data;
                  end
                  k_q  <= k_q + K_W'(1);
                  z2_q <= z2_n;
                  z4_q <= z4_n;
                  if (last_beat) cf_q <= classify(z2_n, z4_n);
               end
            end
            OUT: begin
               if (bus.fill_ready) begin
                  case (cf_q)
                     2'b00:   cnt_cf0 <= cnt_cf0 + CNT_W'(1);
                     2'b01:   cnt_cf1 <= cnt_cf1 + CNT_W'(1);
                     2'b10:   cnt_cf2 <= cnt_cf2 + CNT_W'(1);
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_line_fill_compressor.sv
// tb_line_fill_compressor
//   Directed bench for line_fill_compressor: CF classification of hand-built
//   lines, request/fill backpressure, stray beats, back-to-back misses and
//   reset in the middle of a fill.
module tb_line_fill_compressor;

   localparam int ADDR_W = 32;
   localparam int BEAT_W = 64;
   localparam int LINE_W = 512;
   localparam int CNT_W  = 32;
   localparam int NB     = 8;

   logic clock = 1'b0;
   logic reset;
   logic [CNT_W-1:0] cnt_cf0, cnt_cf1, cnt_cf2;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt[3];

   line_fill_compressor_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .LINE_W(LINE_W)) bus ();

   line_fill_compressor #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .cnt_cf0 (cnt_cf0),
      .cnt_cf1 (cnt_cf1),
      .cnt_cf2 (cnt_cf2)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_counters();
      check("cnt_cf0", cnt_cf0, exp_cnt[0]);
      check("cnt_cf1", cnt_cf1, exp_cnt[1]);
      check("cnt_cf2", cnt_cf2, exp_cnt[2]);
   endtask

   task automatic check_reset_state();
      check("rst_miss_ready", bus.miss_ready, 1);
      check("rst_req_valid", bus.mem_req_valid, 0);
      check("rst_fill_valid", bus.fill_valid, 0);
      check("rst_fill_addr", bus.fill_addr, 0);
      check("rst_fill_data", bus.fill_data, 0);
      check("rst_fill_cf", bus.fill_cf, 0);
      check_counters();
   endtask

   task automatic send_miss(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] aligned);
      bus.miss_valid = 1'b1;
      bus.miss_addr  = a;
      tick();
      bus.miss_valid = 1'b0;
      check("req_valid", bus.mem_req_valid, 1);
      check("req_addr", bus.mem_req_addr, aligned);
      check("miss_ready_req", bus.miss_ready, 0);
   endtask

   task automatic grant_req(input int wait_n, input bit stray, input logic [ADDR_W-1:0] aligned);
      for (int i = 0; i < wait_n; i++) begin
         if (stray) begin
            bus.mem_beat_valid = 1'b1;
            bus.mem_beat_data  = 64'hA5A5_A5A5_A5A5_A5A5;
         end
         tick();
         check("req_hold_valid", bus.mem_req_valid, 1);
         check("req_hold_addr", bus.mem_req_addr, aligned);
         check("req_hold_miss_ready", bus.miss_ready, 0);
      end
      bus.mem_beat_valid = 1'b0;
      bus.mem_req_ready  = 1'b1;
      tick();
      bus.mem_req_ready  = 1'b0;
      check("req_drop", bus.mem_req_valid, 0);
   endtask

   task automatic send_beats(input logic [LINE_W-1:0] ln, input int gap, input int nb);
      for (int i = 0; i < nb; i++) begin
         bus.mem_beat_valid = 1'b1;
         bus.mem_beat_data  = ln[i*BEAT_W +: BEAT_W];
         tick();
         bus.mem_beat_valid = 1'b0;
         if (i < NB - 1) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               check("fill_gap_valid", bus.fill_valid, 0);
            end
         end
      end
   endtask

   task automatic finish_fill(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] ln,
                              input logic [1:0] cf, input int stall_n, input bit stray);
      check("fill_valid", bus.fill_valid, 1);
      check("fill_addr", bus.fill_addr, a);
      check("fill_data", bus.fill_data, ln);
      check("fill_cf", bus.fill_cf, cf);
      check("miss_ready_out", bus.miss_ready, 0);
      for (int i = 0; i < stall_n; i++) begin
         if (stray) begin
            bus.mem_beat_valid = 1'b1;
            bus.mem_beat_data  = 64'hFFFF_FFFF_FFFF_FFFF;
         end
         tick();
         check("stall_valid", bus.fill_valid, 1);
         check("stall_addr", bus.fill_addr, a);
         check("stall_data", bus.fill_data, ln);
         check("stall_cf", bus.fill_cf, cf);
         check("stall_miss_ready", bus.miss_ready, 0);
         check_counters();
      end
      bus.mem_beat_valid = 1'b0;
      bus.fill_ready     = 1'b1;
      tick();
      bus.fill_ready     = 1'b0;
      exp_cnt[cf]++;
      check_counters();
      check("fill_drop", bus.fill_valid, 0);
      check("miss_ready_idle", bus.miss_ready, 1);
   endtask

   initial begin
      logic [LINE_W-1:0] ln;
      logic [LINE_W-1:0] prev;

      reset              = 1'b1;
      bus.miss_valid     = 1'b0;
      bus.miss_addr      = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_beat_valid = 1'b0;
      bus.mem_beat_data  = '0;
      bus.fill_ready     = 1'b0;
      exp_cnt            = '{0, 0, 0};
      tick();
      tick();
      reset = 1'b0;
      check_reset_state();

      // /2 line: lower half 0x1111.., upper half zero
      ln = '0;
      for (int i = 0; i < 4; i++) ln[i*BEAT_W +: BEAT_W] = 64'h1111_1111_1111_1111;
      send_miss(32'h0000_1A7F, 32'h0000_1A40);
      grant_req(0, 1'b0, 32'h0000_1A40);
      send_beats(ln, 0, NB);
      finish_fill(32'h0000_1A7F, ln, 2'b01, 0, 1'b0);
      check("upper_half_zero", bus.fill_data[511:256], 0);

      // /4 line with request wait, stray beats in REQ/OUT, beat gaps, fill stall
      ln = '0;
      ln[0*BEAT_W +: BEAT_W] = 64'hDEAD_BEEF_0000_0001;
      ln[1*BEAT_W +: BEAT_W] = 64'h8000_0000_0000_0000;
      send_miss(32'h0000_2345, 32'h0000_2340);
      grant_req(5, 1'b1, 32'h0000_2340);
      send_beats(ln, 2, NB);
      finish_fill(32'h0000_2345, ln, 2'b10, 4, 1'b1);
      prev = ln;

      // stray beats in IDLE leave the held line alone
      bus.mem_beat_valid = 1'b1;
      bus.mem_beat_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      tick();
      bus.mem_beat_valid = 1'b0;
      check("idle_stray_data", bus.fill_data, prev);
      check("idle_stray_cf", bus.fill_cf, 2'b10);

      // all-zero line
      ln = '0;
      send_miss(32'h0000_3000, 32'h0000_3000);
      grant_req(1, 1'b0, 32'h0000_3000);
      send_beats(ln, 0, NB);
      finish_fill(32'h0000_3000, ln, 2'b10, 0, 1'b0);

      // only beat 7 nonzero -> uncompressed
      ln = '0;
      ln[7*BEAT_W +: BEAT_W] = 64'h1;
      send_miss(32'h0000_4001, 32'h0000_4000);
      grant_req(0, 1'b0, 32'h0000_4000);
      send_beats(ln, 1, NB);
      finish_fill(32'h0000_4001, ln, 2'b00, 0, 1'b0);

      // only beat 3 nonzero -> /2, with a second miss held during OUT
      ln = '0;
      ln[3*BEAT_W +: BEAT_W] = 64'h0000_0000_00C0_FFEE;
      send_miss(32'h0000_5555, 32'h0000_5540);
      grant_req(0, 1'b0, 32'h0000_5540);
      send_beats(ln, 0, NB);
      bus.miss_valid = 1'b1;
      bus.miss_addr  = 32'h0000_6789;
      finish_fill(32'h0000_5555, ln, 2'b01, 2, 1'b0);
      check("b2b_not_yet", bus.mem_req_valid, 0);
      tick();
      bus.miss_valid = 1'b0;
      check("b2b_req_valid", bus.mem_req_valid, 1);
      check("b2b_req_addr", bus.mem_req_addr, 32'h0000_6780);
      check("b2b_miss_ready", bus.miss_ready, 0);
      grant_req(0, 1'b0, 32'h0000_6780);
      ln = {8{64'h0123_4567_89AB_CDEF}};
      send_beats(ln, 0, NB);
      finish_fill(32'h0000_6789, ln, 2'b00, 0, 1'b0);

      // reset after beat 3 of a fill
      ln = {8{64'hFFFF_FFFF_FFFF_FFFF}};
      send_miss(32'h0000_7000, 32'h0000_7000);
      grant_req(0, 1'b0, 32'h0000_7000);
      send_beats(ln, 0, 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_cnt = '{0, 0, 0};
      check_reset_state();
      bus.mem_beat_valid = 1'b1;
      bus.mem_beat_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      bus.mem_beat_valid = 1'b0;
      check("post_rst_stray_data", bus.fill_data, 0);
      check("post_rst_idle", bus.miss_ready, 1);

      ln = '0;
      ln[0*BEAT_W +: BEAT_W] = 64'h5;
      send_miss(32'h0000_8008, 32'h0000_8000);
      grant_req(0, 1'b0, 32'h0000_8000);
      send_beats(ln, 0, NB);
      finish_fill(32'h0000_8008, ln, 2'b10, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
